// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a}, the all-anodes-off word, digit slots and scan states.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [7:0] AN_OFF   = 8'hFF;

    // Slot numbers double as anode bit positions and blink_mask bit positions.
    localparam logic [2:0] DIG_S2 = 3'd0;
    localparam logic [2:0] DIG_S1 = 3'd1;
    localparam logic [2:0] DIG_M2 = 3'd2;
    localparam logic [2:0] DIG_M1 = 3'd3;
    localparam logic [2:0] DIG_H2 = 3'd4;
    localparam logic [2:0] DIG_H1 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DRIVE
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Six-digit multiplexed seven-segment driver with a one-cycle ghost guard,
// per-frame input latch, field blinking and hours-tens leading-zero blanking.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1_000,
    parameter int BLINK_HZ   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [5:0] blink_mask,
    input  logic       lz_en,
    output logic [6:0] seg,
    output logic [7:0] an
);

    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int HB  = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (HB > 1) ? $clog2(HB) : 1;

    logic [PW-1:0] presc;
    logic [BW-1:0] bc;
    logic          blink_ph;
    logic [2:0]    idx;
    logic          started;
    logic [23:0]   frame;
    scan_state_t   state;

    logic          tick;
    logic          bc_wrap;
    logic          latch_now;
    logic [2:0]    idx_next;
    logic [23:0]   live_frame;
    logic [23:0]   frame_next;
    logic [3:0]    digit_next;
    logic [6:0]    pattern_next;
    logic          blank;

    assign tick       = (presc == PW'(DIV - 1));
    assign bc_wrap    = (bc == BW'(HB - 1));
    assign live_frame = {h1, h2, m1, m2, s1, s2};

    // The first tick after reset shows slot 0 instead of advancing, so the
    // frame always starts from the seconds-units digit with fresh data.
    always_comb begin
        latch_now  = !started || (idx == DIG_H1);
        idx_next   = DIG_S2;
        if (started && (idx != DIG_H1)) begin
            idx_next = idx + 3'd1;
        end
        frame_next = latch_now ? live_frame : frame;
        digit_next = frame_next[{idx_next, 2'b00} +: 4];
        blank      = (blink_mask[idx] && !blink_ph) ||
                     ((idx == DIG_H1) && (frame[23:20] == 4'd0) && lz_en);
    end

    bcd_to_seg7 u_dec (
        .bcd     (digit_next),
        .pattern (pattern_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            bc       <= '0;
            blink_ph <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            bc    <= bc_wrap ? '0 : bc + BW'(1);
            if (bc_wrap) begin
                blink_ph <= ~blink_ph;
            end
        end
    end

    // Tick blanks the anodes and loads the new pattern; the guard cycle then
    // enables the anode, which is held until the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= DIG_S2;
            started <= 1'b0;
            frame   <= '0;
            state   <= ST_IDLE;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
        end else if (tick) begin
            idx     <= idx_next;
            started <= 1'b1;
            if (latch_now) begin
                frame <= live_frame;
            end
            an    <= AN_OFF;
            seg   <= pattern_next;
            state <= ST_GUARD;
        end else begin
            case (state)
                ST_GUARD: begin
                    state <= ST_DRIVE;
                    if (!blank) begin
                        an <= ~(8'd1 << idx);
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule
